viterbi_sched: RTL

VITERBI_SCHED -- requirements
Module: viterbi_sched

---
 rtl/viterbi_sched.sv | 123 ++++++++++++
 1 files changed

// File: rtl/viterbi_sched.sv
// Two-channel round-robin front end feeding one Viterbi decoder core, one frame in flight.
// Optional RUN watchdog: define VITERBI_SCHED_TIMEOUT_EN to abort a stalled decode after TIMEOUT cycles.
module viterbi_sched #(
  parameter int FRAME_W = 14,
  parameter int DATA_W  = 7,
  parameter int TIMEOUT = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0,
  input  logic [FRAME_W-1:0] frame0,
  output logic               ack0,
  input  logic               req1,
  input  logic [FRAME_W-1:0] frame1,
  output logic               ack1,
  output logic               core_start,
  output logic [FRAME_W-1:0] core_frame,
  input  logic               core_done,
  input  logic [DATA_W-1:0]  core_data,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_ch,
  input  logic               out_ready,
  output logic               busy,
  output logic               err
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, HOLD} state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_ch;
  logic               r_prio1;
  logic               r_out_ch;
  logic [FRAME_W-1:0] r_frame;
  logic [DATA_W-1:0]  r_out_data;
  logic               w_any_req;
  logic               w_grant_ch;
  logic               w_timeout;

  // r_prio1 set means channel 1 wins a tie; cleared by reset so channel 0 wins first.
  assign w_any_req  = req0 | req1;
  assign w_grant_ch = (req0 & req1) ? r_prio1 : req1;

`ifdef VITERBI_SCHED_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || r_state != RUN) r_cnt <= '0;
    else                          r_cnt <= r_cnt + 1'b1;
  end

  // A core_done arriving in the expiry cycle takes precedence over the abort.
  assign w_timeout = (r_state == RUN) && !core_done && (r_cnt == CNT_W'(TIMEOUT - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_any_req) w_next = LOAD;
      LOAD:    w_next = RUN;
      RUN: begin
        if (core_done)      w_next = HOLD;
        else if (w_timeout) w_next = IDLE;
      end
      HOLD:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    ack0       = 1'b0;
    ack1       = 1'b0;
    core_start = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    err        = 1'b0;
    case (r_state)
      IDLE: busy = 1'b0;
      LOAD: begin
        core_start = 1'b1;
        ack0       = ~r_ch;
        ack1       = r_ch;
      end
      RUN:  err = w_timeout;
      HOLD: out_valid = 1'b1;
      default: busy = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_frame    <= '0;
      r_ch       <= 1'b0;
      r_prio1    <= 1'b0;
      r_out_data <= '0;
      r_out_ch   <= 1'b0;
    end else begin
      if (r_state == IDLE && w_any_req) begin
        r_frame <= w_grant_ch ? frame1 : frame0;
        r_ch    <= w_grant_ch;
        r_prio1 <= ~w_grant_ch;
      end
      if (r_state == RUN && core_done) begin
        r_out_data <= core_data;
        r_out_ch   <= r_ch;
      end
    end
  end

  assign core_frame = r_frame;
  assign out_data   = r_out_data;
  assign out_ch     = r_out_ch;

endmodule
